// File: rtl/fifo_window_pkg.sv
// -----------------------------------------------------------------------------
// fifo_window_pkg
// Shared definitions for the 3x3 window generator:
//   - default geometry (pixel width, frame size, index width)
//   - frame controller state encoding
//   - window geometry and element-index helper
// -----------------------------------------------------------------------------
package fifo_window_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IMG_W_DEF  = 320;
  localparam int IMG_H_DEF  = 240;
  localparam int IDX_W_DEF  = 10;

  // Frame controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Window geometry: element k = r*WIN_COLS + c, r=0 oldest row, c=0 leftmost
  localparam int WIN_ROWS    = 3;
  localparam int WIN_COLS    = 3;
  localparam int WIN_ELEMS   = WIN_ROWS * WIN_COLS;
  localparam int WIN_COL_NEW = WIN_COLS - 1;

  // Flat element index of window position (r, c)
  function automatic int win_idx(input int r, input int c);
    return r * WIN_COLS + c;
  endfunction

endpackage

// File: rtl/fifo_window3x3_gen_line_buffer_ram.sv
// -----------------------------------------------------------------------------
// line_buffer_ram
// Single-port line store, DEPTH x DATA_W. Read is asynchronous on the current
// address, write is synchronous, so a read in the same cycle as a write to the
// same address returns the old contents (read-before-write). Not reset.
// Ports:
//   i_clk  - clock
//   we     - write enable
//   addr   - read/write address (column)
//   wdata  - write data
//   rdata  - contents of addr before this cycle's write
// -----------------------------------------------------------------------------
module line_buffer_ram
  import fifo_window_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = IMG_W_DEF,
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Synchronous write port; contents are intentionally left unreset
  always_ff @(posedge i_clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/fifo_window3x3_gen.sv
// -----------------------------------------------------------------------------
// fifo_window3x3_gen
// Drains one frame of pixels from the pixel FIFO after i_start and emits an
// unpadded 3x3 window for every interior pixel, in raster order.
// Ports:
//   i_clk        - system clock, rising edge
//   i_reset      - asynchronous active-low reset
//   i_start      - start one frame (only honoured in IDLE)
//   i_fifoEmpty  - pixel FIFO empty flag
//   i_fifoData   - FIFO read data, valid the cycle after o_rdFifo
//   o_rdFifo     - FIFO read enable
//   o_window     - 3x3 window, element k=r*3+c at [DATA_W*k +: DATA_W]
//   o_winValid   - window/centre outputs valid this cycle
//   o_winX/Y     - centre column/row of the window
//   o_busy       - high while draining a frame
//   o_frameDone  - one-cycle pulse after the last pixel is accepted
// -----------------------------------------------------------------------------
module fifo_window3x3_gen
  import fifo_window_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_fifoEmpty,
  input  logic [DATA_W-1:0]     i_fifoData,
  output logic                  o_rdFifo,
  output logic [9*DATA_W-1:0]   o_window,
  output logic                  o_winValid,
  output logic [IDX_W-1:0]      o_winX,
  output logic [IDX_W-1:0]      o_winY,
  output logic                  o_busy,
  output logic                  o_frameDone
);

  localparam int PIX_TOTAL = IMG_W * IMG_H;
  localparam int CNT_W     = $clog2(PIX_TOTAL + 1);
  localparam int ADDR_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [CNT_W-1:0] PIX_TOTAL_C = CNT_W'(PIX_TOTAL);
  localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
  localparam logic [IDX_W-1:0] COL_LAST_C  = IDX_W'(IMG_W - 1);
  localparam logic [IDX_W-1:0] ROW_LAST_C  = IDX_W'(IMG_H - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO_C  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE_C   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TWO_C   = IDX_W'(2);

  state_e               state_r;
  logic [CNT_W-1:0]     req_cnt_r;
  logic [IDX_W-1:0]     col_r;
  logic [IDX_W-1:0]     row_r;
  logic                 rd_d1_r;
  logic                 busy_r;
  logic                 frame_done_r;
  logic                 win_valid_r;
  logic [IDX_W-1:0]     win_x_r;
  logic [IDX_W-1:0]     win_y_r;
  logic [DATA_W-1:0]    win_r [WIN_ELEMS];

  logic                 rd_fifo_s;
  logic                 last_px_s;
  logic                 win_ok_s;
  logic                 start_s;
  logic [DATA_W-1:0]    lb0_rdata_s;
  logic [DATA_W-1:0]    lb1_rdata_s;
  logic [DATA_W-1:0]    new_col_s [WIN_ROWS];
  logic [ADDR_W-1:0]    lb_addr_s;

  // FIFO read request: only in RUN, FIFO non-empty and frame not fully requested
  always_comb begin
    rd_fifo_s = 1'b0;
    if ((state_r == RUN) && !i_fifoEmpty && (req_cnt_r < PIX_TOTAL_C)) begin
      rd_fifo_s = 1'b1;
    end else begin
      rd_fifo_s = 1'b0;
    end
  end

  assign start_s   = (state_r == IDLE) && i_start;
  assign last_px_s = rd_d1_r && (col_r == COL_LAST_C) && (row_r == ROW_LAST_C);
  // Requiring row>=2 and col>=2 excludes both line-wrap windows and stale
  // line-buffer contents from an earlier or aborted frame.
  assign win_ok_s  = (row_r >= IDX_TWO_C) && (col_r >= IDX_TWO_C);
  assign lb_addr_s = col_r[ADDR_W-1:0];

  // New right-hand window column, top (oldest line) to bottom (current pixel)
  assign new_col_s[0] = lb1_rdata_s;
  assign new_col_s[1] = lb0_rdata_s;
  assign new_col_s[2] = i_fifoData;

  // linebuf0 holds the previous line, linebuf1 the one before it
  line_buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_linebuf0 (
    .i_clk  (i_clk),
    .we     (rd_d1_r),
    .addr   (lb_addr_s),
    .wdata  (i_fifoData),
    .rdata  (lb0_rdata_s)
  );

  line_buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .ADDR_W (ADDR_W)
  ) u_linebuf1 (
    .i_clk  (i_clk),
    .we     (rd_d1_r),
    .addr   (lb_addr_s),
    .wdata  (lb0_rdata_s),
    .rdata  (lb1_rdata_s)
  );

  // Frame controller: state, request count, read pipeline, busy/done flags
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r      <= IDLE;
      req_cnt_r    <= '0;
      rd_d1_r      <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      rd_d1_r <= rd_fifo_s;
      case (state_r)
        IDLE: begin
          frame_done_r <= 1'b0;
          if (i_start) begin
            state_r   <= RUN;
            busy_r    <= 1'b1;
            req_cnt_r <= '0;
          end else begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
          end
        end
        RUN: begin
          if (rd_fifo_s) begin
            req_cnt_r <= req_cnt_r + CNT_ONE_C;
          end
          if (last_px_s) begin
            state_r      <= DONE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b1;
          end else begin
            state_r      <= RUN;
            busy_r       <= 1'b1;
            frame_done_r <= 1'b0;
          end
        end
        DONE: begin
          state_r      <= IDLE;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      col_r <= '0;
      row_r <= '0;
    end else if (start_s) begin
      col_r <= '0;
      row_r <= '0;
    end else if (rd_d1_r) begin
      if (col_r == COL_LAST_C) begin
        col_r <= IDX_ZERO_C;
        row_r <= row_r + IDX_ONE_C;
      end else begin
        col_r <= col_r + IDX_ONE_C;
      end
    end
  end

  // Window shift register and registered valid/centre outputs
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < WIN_ELEMS; k++) begin
        win_r[k] <= '0;
      end
      win_valid_r <= 1'b0;
      win_x_r     <= '0;
      win_y_r     <= '0;
    end else begin
      win_valid_r <= rd_d1_r && win_ok_s;
      if (rd_d1_r) begin
        for (int r = 0; r < WIN_ROWS; r++) begin
          for (int c = 0; c < WIN_COL_NEW; c++) begin
            win_r[win_idx(r, c)] <= win_r[win_idx(r, c + 1)];
          end
          win_r[win_idx(r, WIN_COL_NEW)] <= new_col_s[r];
        end
        if (win_ok_s) begin
          win_x_r <= col_r - IDX_ONE_C;
          win_y_r <= row_r - IDX_ONE_C;
        end
      end
    end
  end

  // Flatten the window registers onto the output bus
  always_comb begin
    o_window = '0;
    for (int k = 0; k < WIN_ELEMS; k++) begin
      o_window[DATA_W*k +: DATA_W] = win_r[k];
    end
  end

  assign o_rdFifo    = rd_fifo_s;
  assign o_winValid  = win_valid_r;
  assign o_winX      = win_x_r;
  assign o_winY      = win_y_r;
  assign o_busy      = busy_r;
  assign o_frameDone = frame_done_r;

endmodule

// File: tb/tb_fifo_window3x3_gen.sv
// -----------------------------------------------------------------------------
// tb_fifo_window3x3_gen
// Self-checking bench: a reset/idle vector table on an 8x4 instance, randomized
// FIFO-stall frames on the 8x4 instance, and one full 320x240 frame. Expected
// windows are built directly from pixel coordinates.
// -----------------------------------------------------------------------------
module tb_fifo_window3x3_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small (8x4) instance
  logic        s_reset = 1'b0, s_start = 1'b0, s_empty = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_rd, s_valid, s_busy, s_done;
  logic [71:0] s_win;
  logic [9:0]  s_x, s_y;

  // Default (320x240) instance
  logic        d_reset = 1'b0, d_start = 1'b0, d_empty = 1'b0;
  logic [7:0]  d_data = 8'd0;
  logic        d_rd, d_valid, d_busy, d_done;
  logic [71:0] d_win;
  logic [9:0]  d_x, d_y;

  fifo_window3x3_gen #(.DATA_W(8), .IMG_W(8), .IMG_H(4), .IDX_W(10)) u_small (
    .i_clk(clk), .i_reset(s_reset), .i_start(s_start), .i_fifoEmpty(s_empty),
    .i_fifoData(s_data), .o_rdFifo(s_rd), .o_window(s_win), .o_winValid(s_valid),
    .o_winX(s_x), .o_winY(s_y), .o_busy(s_busy), .o_frameDone(s_done));

  fifo_window3x3_gen u_dflt (
    .i_clk(clk), .i_reset(d_reset), .i_start(d_start), .i_fifoEmpty(d_empty),
    .i_fifoData(d_data), .o_rdFifo(d_rd), .o_window(d_win), .o_winValid(d_valid),
    .o_winX(d_x), .o_winY(d_y), .o_busy(d_busy), .o_frameDone(d_done));

  // Observed outputs of whichever instance is under test
  bit          sel_d = 1'b0;
  logic        c_rd, c_valid, c_busy, c_done;
  logic [71:0] c_win;
  logic [9:0]  c_x, c_y;
  always_comb begin
    if (sel_d) begin
      c_rd = d_rd; c_valid = d_valid; c_busy = d_busy; c_done = d_done;
      c_win = d_win; c_x = d_x; c_y = d_y;
    end else begin
      c_rd = s_rd; c_valid = s_valid; c_busy = s_busy; c_done = s_done;
      c_win = s_win; c_x = s_x; c_y = s_y;
    end
  end

  int n_pass  = 0;
  int n_total = 0;
  int rd_cyc [76800];

  task automatic chk(input string name, input bit ok, input string got, input string exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, got, exp);
  endtask

  // Pixel content of the reference frames
  function automatic logic [7:0] pix(input bit use_d, input int x, input int y);
    if (use_d) return 8'((x * 7 + y * 13 + ((x * y) >> 3)) & 255);
    else       return 8'(y * 8 + x);
  endfunction

  // Reference 3x3 window centred on (x, y)
  function automatic logic [71:0] exp_win(input bit use_d, input int x, input int y);
    logic [71:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        v[8*(r*3+c) +: 8] = pix(use_d, x - 1 + c, y - 1 + r);
    return v;
  endfunction

  task automatic drive(input bit use_d, input bit start, input bit empty, input logic [7:0] data);
    if (use_d) begin d_start = start; d_empty = empty; d_data = data; end
    else       begin s_start = start; s_empty = empty; s_data = data; end
  endtask

  // Runs one frame. stall_pct: % of cycles FIFO reads empty; poke_cyc: cycle at
  // which i_start is pulsed mid-frame (-1 none); abort_px: reset once this pixel
  // index has been accepted (-1 none).
  task automatic run_frame(input bit use_d, input int stall_pct, input int poke_cyc, input int abort_px);
    int w, h, total, nwin, budget, n, rd_cnt, win_i, done_cnt, done_cyc, ex, ey, ecyc, bi;
    bit rd_now, emp, st, ok;
    logic [71:0] ew;
    logic [7:0] dat;
    w = use_d ? 320 : 8;
    h = use_d ? 240 : 4;
    total = w * h;
    nwin = (w - 2) * (h - 2);
    budget = use_d ? total + 100 : total * 20 + 100;
    n = 0; rd_cnt = 0; win_i = 0; done_cnt = 0; done_cyc = -1;
    sel_d = use_d;
    drive(use_d, 1'b1, 1'b1, 8'd0);
    @(posedge clk); #1;
    dat = 8'($urandom);
    while (n < budget) begin
      emp = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
      st = (n == poke_cyc);
      drive(use_d, st, emp, dat);
      @(negedge clk);
      if (st) chk("busy_during_poke", c_busy == 1'b1, $sformatf("%0b", c_busy), "1");
      if (c_valid) begin
        ex = 1 + win_i % (w - 2);
        ey = 1 + win_i / (w - 2);
        ew = exp_win(use_d, ex, ey);
        bi = (ey + 1) * w + ex + 1;
        ecyc = (bi < rd_cnt) ? rd_cyc[bi] + 2 : -1;
        ok = (win_i < nwin) && (c_win == ew) && (c_x == 10'(ex)) && (c_y == 10'(ey)) && (n == ecyc);
        chk($sformatf("window%0d", win_i), ok,
            $sformatf("win=%h x=%0d y=%0d cyc=%0d", c_win, c_x, c_y, n),
            $sformatf("win=%h x=%0d y=%0d cyc=%0d", ew, ex, ey, ecyc));
        win_i++;
      end
      if (c_done) begin
        done_cnt++;
        done_cyc = n;
      end
      rd_now = c_rd;
      if (rd_now && rd_cnt < total) rd_cyc[rd_cnt] = n;
      if (rd_now) rd_cnt++;
      @(posedge clk); #1;
      dat = rd_now ? pix(use_d, (rd_cnt - 1) % w, (rd_cnt - 1) / w) : 8'($urandom);
      if (abort_px >= 0 && rd_cnt > abort_px && n + 1 >= rd_cyc[abort_px] + 2) begin
        if (use_d) d_reset = 1'b0; else s_reset = 1'b0;
        #1;
        chk("abort_outputs_zero",
            {c_rd, c_valid, c_busy, c_done} == 4'b0 && c_win == 72'd0 && c_x == 10'd0 && c_y == 10'd0,
            $sformatf("rd=%0b v=%0b b=%0b d=%0b win=%h x=%0d y=%0d", c_rd, c_valid, c_busy, c_done, c_win, c_x, c_y),
            "all zero");
        drive(use_d, 1'b0, 1'b0, 8'd0);
        @(posedge clk); #1;
        if (use_d) d_reset = 1'b1; else s_reset = 1'b1;
        return;
      end
      n++;
      if (done_cyc >= 0 && n > done_cyc + 5) break;
    end
    drive(use_d, 1'b0, 1'b0, 8'd0);
    chk("window_count", win_i == nwin, $sformatf("%0d", win_i), $sformatf("%0d", nwin));
    chk("read_count", rd_cnt == total, $sformatf("%0d", rd_cnt), $sformatf("%0d", total));
    chk("frame_done_count", done_cnt == 1, $sformatf("%0d", done_cnt), "1");
    chk("frame_done_timing", rd_cnt >= total && done_cyc == rd_cyc[total-1] + 2,
        $sformatf("%0d", done_cyc), $sformatf("%0d", (rd_cnt >= total) ? rd_cyc[total-1] + 2 : -1));
    chk("busy_after_frame", c_busy == 1'b0, $sformatf("%0b", c_busy), "0");
  endtask

  typedef struct {
    bit rst;
    bit start;
    bit empty;
    bit exp_rd;
    bit exp_busy;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{rst:1'b0, start:1'b1, empty:1'b0, exp_rd:1'b0, exp_busy:1'b0};
    vecs[1] = '{rst:1'b0, start:1'b1, empty:1'b0, exp_rd:1'b0, exp_busy:1'b0};
    vecs[2] = '{rst:1'b1, start:1'b0, empty:1'b0, exp_rd:1'b0, exp_busy:1'b0};
    vecs[3] = '{rst:1'b1, start:1'b0, empty:1'b1, exp_rd:1'b0, exp_busy:1'b0};
    vecs[4] = '{rst:1'b1, start:1'b1, empty:1'b1, exp_rd:1'b0, exp_busy:1'b1};
    vecs[5] = '{rst:1'b1, start:1'b0, empty:1'b0, exp_rd:1'b1, exp_busy:1'b1};
    vecs[6] = '{rst:1'b0, start:1'b0, empty:1'b0, exp_rd:1'b0, exp_busy:1'b0};
    vecs[7] = '{rst:1'b0, start:1'b1, empty:1'b0, exp_rd:1'b0, exp_busy:1'b0};

    sel_d = 1'b0;
    #2;
    for (int i = 0; i < 8; i++) begin
      s_reset = vecs[i].rst;
      s_start = vecs[i].start;
      s_empty = vecs[i].empty;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rd_busy", i), s_rd == vecs[i].exp_rd && s_busy == vecs[i].exp_busy,
          $sformatf("rd=%0b busy=%0b", s_rd, s_busy),
          $sformatf("rd=%0b busy=%0b", vecs[i].exp_rd, vecs[i].exp_busy));
      chk($sformatf("vec%0d_quiet", i),
          s_valid == 1'b0 && s_done == 1'b0 && s_win == 72'd0 && s_x == 10'd0 && s_y == 10'd0,
          $sformatf("v=%0b d=%0b win=%h x=%0d y=%0d", s_valid, s_done, s_win, s_x, s_y), "all zero");
    end
    s_start = 1'b0;
    s_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_frame(1'b0, 0, -1, -1);
    run_frame(1'b0, 50, -1, -1);
    run_frame(1'b0, 50, 10, -1);
    run_frame(1'b0, 0, -1, -1);
    run_frame(1'b0, 30, -1, 13);
    repeat (2) @(posedge clk);
    #1;
    run_frame(1'b0, 0, -1, -1);

    d_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_frame(1'b1, 0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_window3x3_gen.md
Name: fifo_window3x3_gen

Overview:
Downstream consumer of the camera-to-FIFO write controller. Drains the pixel FIFO for one frame when started. Keeps two line buffers and emits a 3x3 pixel window, without padding, for every interior pixel. Feeds the first convolution (MobileNet) stage.

Parameters:
DATA_W, 8, pixel width in bits
IMG_W, 320, pixels per line
IMG_H, 240, lines per frame
IDX_W, 10, width of the column/row counters and of o_winX/o_winY

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  start one frame; sampled in IDLE only
i_fifoEmpty  in  1  pixel FIFO empty flag
i_fifoData  in  DATA_W  FIFO read data; valid the cycle after o_rdFifo
o_rdFifo  out  1  FIFO read enable
o_window  out  9*DATA_W  window; element k=r*3+c at [DATA_W*k +: DATA_W]; r=0 is the oldest row, c=0 is the leftmost column
o_winValid  out  1  o_window, o_winX and o_winY are valid this cycle
o_winX  out  IDX_W  column of the window centre
o_winY  out  IDX_W  row of the window centre
o_busy  out  1  high in RUN
o_frameDone  out  1  one-cycle pulse after the last pixel of the frame

Behaviour:
- Reset (i_reset=0, async):
  - all outputs 0; state IDLE; counters 0.
  - line-buffer RAM contents are not reset.
- States:
  - IDLE: i_start=1 -> RUN; clears col, row and the request count.
  - RUN: o_rdFifo = !i_fifoEmpty && (request count < IMG_W*IMG_H). Combinational from state, i_fifoEmpty and the request count.
  - DONE: entered the cycle after the last pixel is accepted. o_frameDone=1 for exactly one cycle, then unconditionally IDLE.
- i_start is ignored in RUN and DONE.
- Pixel acceptance:
  - rdD1 is o_rdFifo registered; a pixel is accepted on each cycle with rdD1=1.
  - For each accepted pixel at (col,row):
    - read linebuf0[col] and linebuf1[col] (read-before-write);
    - write linebuf1[col] <= linebuf0[col] and linebuf0[col] <= i_fifoData;
    - shift the three 3-wide window rows left, inserting {linebuf1 old, linebuf0 old, i_fifoData} as the new column c=2.
  - col increments and wraps from IMG_W-1 to 0, incrementing row.
- Window output:
  - registered; o_winValid=1 the cycle after an accepted pixel with row>=2 && col>=2.
  - o_winX = col-1, o_winY = row-1.
  - o_winValid=0 on stall cycles; o_window holds its last value.
  - Windows straddling a line wrap (col 0,1) are never flagged valid.
- Latency:
  - o_rdFifo at cycle t -> pixel accepted at t+1 -> window at t+2.
  - Last pixel accepted at t -> o_frameDone at t+1.
- Counts: (IMG_W-2)*(IMG_H-2) valid windows per frame, in raster order.
- FIFO empty mid-frame: reads stall and no pixel is lost or duplicated. Output is identical to the no-stall case apart from timing.
- Read limit: no read is issued once IMG_W*IMG_H reads have been requested, even if the FIFO is non-empty.
- Reset mid-frame: immediate return to IDLE with all outputs 0. The next i_start begins a clean frame; stale line-buffer data is never exposed because of the row>=2 rule.

Decomposition:
- Package fifo_window_pkg:
  - DATA_W, IMG_W, IMG_H, IDX_W defaults;
  - state enum {IDLE, RUN, DONE};
  - window index constants.
- Sub-module line_buffer_ram: single-port, IMG_W x DATA_W, synchronous write, read-before-write. Instantiated twice.

Test Plan:
- Reset: hold i_reset=0 with i_start=1 and FIFO non-empty -> all outputs 0, o_rdFifo=0.
- Small frame, IMG_W=8, IMG_H=4, pixel=y*8+x, FIFO never empty:
  - first o_winValid has window {0,1,2,8,9,10,16,17,18}, winX=1, winY=1;
  - exactly 12 windows, the last with centre (6,2);
  - o_frameDone pulses once, 1 cycle after pixel 31 is accepted;
  - exactly 32 reads are issued.
- Same frame with i_fifoEmpty randomly high 50% of cycles -> identical 12 windows in order, with no valid during stall cycles.
- i_start pulsed during RUN -> ignored and the frame completes normally; a second i_start after o_frameDone -> second frame with identical windows.
- Reset asserted after pixel 13 -> outputs 0 and state IDLE; a new frame after i_start gives correct windows starting {0,1,2,8,9,10,16,17,18}.
- Defaults 320x240 -> 75684 valid windows, the last centred at (318,238); o_frameDone once; 76800 reads.
